// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: register
// offsets of the 8-bit IO window, the request FSM state type and the
// channel-index width helper.
package irq_pkg;

  localparam logic [1:0] REG_ENABLE    = 2'd0;
  localparam logic [1:0] REG_EDGE_SEL  = 2'd1;
  localparam logic [1:0] REG_PENDING   = 2'd2;
  localparam logic [1:0] REG_INSERVICE = 2'd3;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} irq_state_t;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_if.sv
// CPU-facing bundle: interrupt request/vector handshake plus the register
// window on the data/IO bus.
//   master : CPU side (drives ack/eoi and bus strobes)
//   slave  : controller side (drives request, vector, read data)
interface irq_if;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        irq_ack;
  logic        irq_eoi;
  logic [1:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_rdata;

  modport master (
    input  irq_req, irq_vector, io_rdata,
    output irq_ack, irq_eoi, io_addr, io_wdata, io_we, io_re
  );

  modport slave (
    output irq_req, irq_vector, io_rdata,
    input  irq_ack, irq_eoi, io_addr, io_wdata, io_we, io_re
  );
endinterface

// File: rtl/irq_priority_enc.sv
// Combinational lowest-index-set encoder.
//   vec   : input bit vector
//   valid : any bit of vec set
//   idx   : index of the lowest set bit (0 when none set)
module irq_priority_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = |vec;
    idx   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: NUM_IRQ level/edge sources, per-channel
// enable, fixed priority (channel 0 highest), in-service nesting, one
// request plus a 16-bit handler vector to the CPU.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : peripheral sources (synchronous to clk)
//   irq_clr    : one-cycle clear strobe to the acknowledged source
//   bus        : CPU request/ack/eoi handshake and register window
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ       = 8,
  parameter logic [15:0] VECTOR_BASE   = 16'h0008,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_clr,
  irq_if.slave               bus
);
  localparam int IW = idxWidth(NUM_IRQ);

  logic [NUM_IRQ-1:0] enable, edgeSel, pending, inService, irqPrev;
  logic [NUM_IRQ-1:0] eligible, rise, w1c, ackSet, eoiClr, pendNext, latchedOh;
  logic [IW-1:0]      idxQ, eligIdx, isIdx;
  logic               eligValid, isValid, winner, ackNow;
  irq_state_t         state;
  logic               reqQ;
  logic [15:0]        vectorQ;
  logic [7:0]         rdataQ, rdMux;

  function automatic logic [15:0] vecOf(input logic [IW-1:0] i);
    return VECTOR_BASE + 16'(i) * 16'(VECTOR_STRIDE);
  endfunction

  assign eligible = pending & enable;

  irq_priority_enc #(.N(NUM_IRQ), .W(IW)) uEligEnc (
    .vec(eligible), .valid(eligValid), .idx(eligIdx)
  );
  irq_priority_enc #(.N(NUM_IRQ), .W(IW)) uIsEnc (
    .vec(inService), .valid(isValid), .idx(isIdx)
  );

  // Only a strictly higher-priority source than everything in service may
  // preempt; equal priority would re-enter the running handler.
  assign winner = eligValid && (!isValid || (eligIdx < isIdx));

  always_comb begin
    latchedOh       = '0;
    latchedOh[idxQ] = 1'b1;
  end

  assign ackNow = (state == REQ) && bus.irq_ack;
  assign ackSet = ackNow ? latchedOh : '0;
  assign rise   = irq_in & ~irqPrev;
  assign w1c    = (bus.io_we && bus.io_addr == REG_PENDING) ?
                  bus.io_wdata[NUM_IRQ-1:0] : '0;

  // eoi retires the highest-priority in-service level, evaluated on the
  // pre-ack state so a same-cycle ack is never cleared by its own eoi.
  always_comb begin
    eoiClr = '0;
    if (bus.irq_eoi && isValid) eoiClr[isIdx] = 1'b1;
  end

  // Edge channels: a new edge beats both W1C and ack clear in the same cycle.
  // Level channels simply follow the source.
  assign pendNext = (edgeSel & ((pending & ~w1c & ~ackSet) | rise)) |
                    (~edgeSel & irq_in);

  always_comb begin
    rdMux = '0;
    case (bus.io_addr)
      REG_ENABLE:    rdMux[NUM_IRQ-1:0] = enable;
      REG_EDGE_SEL:  rdMux[NUM_IRQ-1:0] = edgeSel;
      REG_PENDING:   rdMux[NUM_IRQ-1:0] = pending;
      REG_INSERVICE: rdMux[NUM_IRQ-1:0] = inService;
      default:       rdMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= '0;
      edgeSel   <= '0;
      pending   <= '0;
      inService <= '0;
      irqPrev   <= '0;
      irq_clr   <= '0;
      rdataQ    <= '0;
      state     <= IDLE;
      reqQ      <= 1'b0;
      idxQ      <= '0;
      vectorQ   <= VECTOR_BASE;
    end else begin
      irqPrev   <= irq_in;
      pending   <= pendNext;
      inService <= (inService & ~eoiClr) | ackSet;
      irq_clr   <= '0;

      if (bus.io_we) begin
        case (bus.io_addr)
          REG_ENABLE:   enable  <= bus.io_wdata[NUM_IRQ-1:0];
          REG_EDGE_SEL: edgeSel <= bus.io_wdata[NUM_IRQ-1:0];
          default: ;
        endcase
      end
      if (bus.io_re) rdataQ <= rdMux;

      case (state)
        IDLE: begin
          if (winner) begin
            idxQ    <= eligIdx;
            vectorQ <= vecOf(eligIdx);
            reqQ    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Index/vector stay frozen here; preemption is re-evaluated in IDLE.
          if (bus.irq_ack) begin
            reqQ    <= 1'b0;
            irq_clr <= latchedOh;
            state   <= IDLE;
          end else if (!eligible[idxQ]) begin
            reqQ  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_req    = reqQ;
  assign bus.irq_vector = vectorQ;
  assign bus.io_rdata   = rdataQ;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  localparam int N = 8;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] irq_clr;
  exp_t         sb[$];
  int           nChk = 0;
  int           nErr = 0;

  irq_if bus ();

  irq_controller #(.NUM_IRQ(N), .VECTOR_BASE(16'h0008), .VECTOR_STRIDE(2)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_clr(irq_clr), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic popChk(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, 32'(obs), 32'(e.val));
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_we    = 1'b1;
    step();
    bus.io_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.io_addr = a;
    bus.io_re   = 1'b1;
    push(tag, 16'(exp));
    step();
    bus.io_re   = 1'b0;
    popChk(16'(bus.io_rdata));
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = irq_in | m;
    step();
    irq_in = irq_in & ~m;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  task automatic eoi();
    bus.irq_eoi = 1'b1;
    step();
    bus.irq_eoi = 1'b0;
  endtask

  // Wait (bounded) for a request, then compare against the queued vector.
  task automatic waitReq(input string tag);
    int n = 0;
    while (!bus.irq_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.irq_req) chk({tag, "_timeout"}, 0, 1);
    popChk(bus.irq_vector);
  endtask

  initial begin
    bus.irq_ack = 0; bus.irq_eoi = 0; bus.io_addr = 0;
    bus.io_wdata = 0; bus.io_we = 0; bus.io_re = 0;
    step(); step();
    reset = 1'b0;
    chk("rst_req", 32'(bus.irq_req), 0);
    chk("rst_vec", 32'(bus.irq_vector), 32'h0008);
    chk("rst_rdata", 32'(bus.io_rdata), 0);
    chk("rst_clr", 32'(irq_clr), 0);

    // 1: single edge source, ack, clear strobe, status readback
    wr(2'd0, 8'h05); wr(2'd1, 8'h05);
    pulse(8'h04);
    chk("t1_req_lat", 32'(bus.irq_req), 0);
    push("t1_vec", 16'h000C);
    step();
    chk("t1_req", 32'(bus.irq_req), 1);
    waitReq("t1");
    ack();
    chk("t1_clr", 32'(irq_clr), 32'h04);
    chk("t1_req_off", 32'(bus.irq_req), 0);
    step();
    chk("t1_clr_1cyc", 32'(irq_clr), 0);
    rd("t1_insvc", 2'd3, 8'h04);
    rd("t1_pend", 2'd2, 8'h00);

    // 2: simultaneous edges, priority order
    eoi();
    rd("t2_insvc0", 2'd3, 8'h00);
    pulse(8'h05);
    push("t2_vec0", 16'h0008);
    waitReq("t2a");
    ack();
    step(); step();
    chk("t2_blocked", 32'(bus.irq_req), 0);
    eoi();
    push("t2_vec2", 16'h000C);
    waitReq("t2b");
    ack();
    rd("t2_insvc", 2'd3, 8'h04);

    // 3: nesting with channel 2 in service
    wr(2'd0, 8'h25); wr(2'd1, 8'h25);
    pulse(8'h01);
    push("t3_vec0", 16'h0008);
    waitReq("t3a");
    ack();
    rd("t3_insvc", 2'd3, 8'h05);
    pulse(8'h20);
    step(); step();
    chk("t3_ch5_blk1", 32'(bus.irq_req), 0);
    eoi();
    step(); step();
    chk("t3_ch5_blk2", 32'(bus.irq_req), 0);
    eoi();
    push("t3_vec5", 16'h0012);
    waitReq("t3b");
    ack();
    eoi();
    rd("t3_insvc_end", 2'd3, 8'h00);

    // W1C alone: clears edge pending, ignored on level channel
    wr(2'd0, 8'h00); wr(2'd1, 8'h01);
    pulse(8'h01);
    rd("w1c_pre", 2'd2, 8'h01);
    wr(2'd2, 8'h01);
    rd("w1c_edge", 2'd2, 8'h00);
    wr(2'd1, 8'h00);
    irq_in = 8'h01;
    step();
    wr(2'd2, 8'h01);
    rd("w1c_level", 2'd2, 8'h01);
    irq_in = 8'h00;
    step(); step();

    // 4: level source drops while requesting
    wr(2'd0, 8'h08);
    irq_in = 8'h08;
    push("t4_vec3", 16'h000E);
    waitReq("t4");
    irq_in = 8'h00;
    step();
    chk("t4_clr_a", 32'(irq_clr), 0);
    step();
    chk("t4_req_drop", 32'(bus.irq_req), 0);
    chk("t4_clr_b", 32'(irq_clr), 0);

    // 5: W1C and new edge in the same cycle
    wr(2'd1, 8'h01); wr(2'd0, 8'h01);
    bus.io_addr = 2'd2; bus.io_wdata = 8'h01; bus.io_we = 1'b1;
    irq_in = 8'h01;
    step();
    bus.io_we = 1'b0;
    irq_in = 8'h00;
    push("t5_vec0", 16'h0008);
    waitReq("t5");
    ack();
    eoi();

    // 6: reset mid-request with channel 2 in service
    wr(2'd0, 8'h05); wr(2'd1, 8'h05);
    pulse(8'h04);
    push("t6_vec2", 16'h000C);
    waitReq("t6a");
    ack();
    pulse(8'h01);
    push("t6_vec0", 16'h0008);
    waitReq("t6b");
    chk("t6_req_pre", 32'(bus.irq_req), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_req_rst", 32'(bus.irq_req), 0);
    chk("t6_vec_rst", 32'(bus.irq_vector), 32'h0008);
    rd("t6_en", 2'd0, 8'h00);
    rd("t6_edge", 2'd1, 8'h00);
    rd("t6_pend", 2'd2, 8'h00);
    rd("t6_insvc", 2'd3, 8'h00);
    ack();
    chk("t6_ack_clr", 32'(irq_clr), 0);
    chk("t6_ack_req", 32'(bus.irq_req), 0);
    step();
    chk("t6_ack_clr2", 32'(irq_clr), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
